// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver state encoding, default frame geometry
// and the oversample-counter width helper used by the receive and transmit paths.
package uart_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_STOP,
        ST_BREAK
    } rx_state_e;

    localparam int OVERSAMPLE_DEFAULT = 16;
    localparam int DATA_BITS_DEFAULT  = 8;

    // Width of a counter that walks through one bit period of oversample ticks.
    function automatic int CNT_W(input int oversample);
        return $clog2(oversample);
    endfunction

endpackage

// File: rtl/uart_sync.sv
// Two-flop synchronizer for a single asynchronous input, with a selectable
// value loaded on reset so an idle line does not look like activity.
module uart_sync #(
    parameter logic RESET_VAL = 1'b0
) (
    input  logic clk,
    input  logic reset,
    input  logic d,
    output logic q
);

    logic meta_q, meta_d;
    logic sync_q, sync_d;

    // Next-state of the chain: each stage takes the one before it.
    always_comb begin
        meta_d = d;
        sync_d = meta_q;
    end

    // Synchronizer stages with synchronous reset to the idle value.
    // NOTE: clocked state uses <= so every flop samples pre-edge values; = here would collapse the chain into one stage.
    always_ff @(posedge clk) begin
        if (reset) begin
            meta_q <= RESET_VAL;
            sync_q <= RESET_VAL;
        end else begin
            meta_q <= meta_d;
            sync_q <= sync_d;
        end
    end

    assign q = sync_q;

endmodule

// File: rtl/uart_receiver.sv
// 8N1-style UART receiver: oversamples the synchronized rx line on rxClk
// enable ticks, recovers frames, and hands bytes to the host with
// ready / frame_err / overrun status.
module uart_receiver
    import uart_pkg::*;
#(
    parameter int OVERSAMPLE = OVERSAMPLE_DEFAULT,
    parameter int DATA_BITS  = DATA_BITS_DEFAULT
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 rxClk,
    input  logic                 rx,
    input  logic                 ready_clr,
    output logic [DATA_BITS-1:0] data,
    output logic                 ready,
    output logic                 frame_err,
    output logic                 overrun,
    output logic                 busy
);

    localparam int                CNT_BITS = CNT_W(OVERSAMPLE);
    localparam int                IDX_W    = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;
    localparam logic [CNT_BITS-1:0] CNT_HALF = CNT_BITS'(OVERSAMPLE / 2 - 1);
    localparam logic [CNT_BITS-1:0] CNT_LAST = CNT_BITS'(OVERSAMPLE - 1);
    localparam logic [IDX_W-1:0]    IDX_LAST = IDX_W'(DATA_BITS - 1);

    logic rx_s;

    rx_state_e            state_q, state_d;
    logic [CNT_BITS-1:0]  cnt_q, cnt_d;
    logic [IDX_W-1:0]     bit_idx_q, bit_idx_d;
    logic [DATA_BITS-1:0] shift_q, shift_d;
    logic [DATA_BITS-1:0] data_q, data_d;
    logic                 ready_q, ready_d;
    logic                 frame_err_q, frame_err_d;
    logic                 overrun_q, overrun_d;

    uart_sync #(.RESET_VAL(1'b1)) u_rx_sync (
        .clk   (clk),
        .reset (reset),
        .d     (rx),
        .q     (rx_s)
    );

    // Frame FSM, bit timing and host-side flags; the FSM only advances on ticks.
    always_comb begin
        // NOTE: every signal gets its hold value first, so no path through the case leaves one unassigned and no latch is inferred.
        state_d     = state_q;
        cnt_d       = cnt_q;
        bit_idx_d   = bit_idx_q;
        shift_d     = shift_q;
        data_d      = data_q;
        ready_d     = ready_q;
        frame_err_d = frame_err_q;
        overrun_d   = overrun_q;

        // Host acknowledge acts every cycle; a completing frame below overrides it.
        if (ready_clr) begin
            ready_d   = 1'b0;
            overrun_d = 1'b0;
        end

        if (rxClk) begin
            unique case (state_q)
                ST_IDLE: begin
                    if (!rx_s) begin
                        state_d = ST_START;
                        cnt_d   = '0;
                    end
                end
                ST_START: begin
                    if (cnt_q == CNT_HALF) begin
                        if (!rx_s) begin
                            state_d   = ST_DATA;
                            cnt_d     = '0;
                            bit_idx_d = '0;
                        end else begin
                            state_d = ST_IDLE;
                        end
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
                ST_DATA: begin
                    if (cnt_q == CNT_LAST) begin
                        // LSB arrives first, so shifting right lands it in bit 0 at the end.
                        shift_d = DATA_BITS'({rx_s, shift_q} >> 1);
                        cnt_d   = '0;
                        if (bit_idx_q == IDX_LAST) begin
                            state_d = ST_STOP;
                        end else begin
                            bit_idx_d = bit_idx_q + 1'b1;
                        end
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
                ST_STOP: begin
                    if (cnt_q == CNT_LAST) begin
                        cnt_d = '0;
                        if (rx_s) begin
                            data_d      = shift_q;
                            frame_err_d = 1'b0;
                            ready_d     = 1'b1;
                            // An unacknowledged byte is being overwritten, unless the host acks on this very cycle.
                            if (ready_q && !ready_clr) begin
                                overrun_d = 1'b1;
                            end
                            state_d = ST_IDLE;
                        end else begin
                            frame_err_d = 1'b1;
                            state_d     = ST_BREAK;
                        end
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
                ST_BREAK: begin
                    // Wait for the line to return high so a held-low line yields one error, not a stream of frames.
                    if (rx_s) begin
                        state_d = ST_IDLE;
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end
    end

    // State and output registers with synchronous active-high reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            // NOTE: the shift register is cleared with the rest; it is a handful of flops, not a memory array, so resetting it is cheap and keeps state deterministic.
            state_q     <= ST_IDLE;
            cnt_q       <= '0;
            bit_idx_q   <= '0;
            shift_q     <= '0;
            data_q      <= '0;
            ready_q     <= 1'b0;
            frame_err_q <= 1'b0;
            overrun_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            bit_idx_q   <= bit_idx_d;
            shift_q     <= shift_d;
            data_q      <= data_d;
            ready_q     <= ready_d;
            frame_err_q <= frame_err_d;
            overrun_q   <= overrun_d;
        end
    end

    assign data      = data_q;
    assign ready     = ready_q;
    assign frame_err = frame_err_q;
    assign overrun   = overrun_q;
    assign busy      = (state_q != ST_IDLE);

endmodule

// File: tb/tb_uart_receiver.sv
// Directed bench for uart_receiver: rxClk ticks every 4 clk cycles, so one
// serial bit is 16 ticks = 64 clk cycles. Inputs change and outputs are
// sampled on the falling edge of clk.
module tb_uart_receiver;

    localparam int BIT_CLKS = 64;

    logic       clk = 1'b0;
    logic       reset;
    logic       rxClk;
    logic       rx;
    logic       ready_clr;
    logic [7:0] data;
    logic       ready;
    logic       frame_err;
    logic       overrun;
    logic       busy;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    uart_receiver #(.OVERSAMPLE(16), .DATA_BITS(8)) dut (
        .clk       (clk),
        .reset     (reset),
        .rxClk     (rxClk),
        .rx        (rx),
        .ready_clr (ready_clr),
        .data      (data),
        .ready     (ready),
        .frame_err (frame_err),
        .overrun   (overrun),
        .busy      (busy)
    );

    // Tick generator: one-cycle rxClk pulse every fourth clk.
    initial begin
        int unsigned div;
        div   = 0;
        rxClk = 1'b0;
        forever begin
            @(negedge clk);
            div   = div + 1;
            rxClk = (div % 4 == 0);
        end
    end

    // Global time limit so the bench can never hang.
    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    task automatic drive_bit(input logic b);
        rx = b;
        repeat (BIT_CLKS) @(negedge clk);
    endtask

    task automatic send_frame(input logic [7:0] v, input logic stop_bit);
        drive_bit(1'b0);
        for (int i = 0; i < 8; i++) drive_bit(v[i]);
        drive_bit(stop_bit);
        rx = 1'b1;
    endtask

    task automatic pulse_clr;
        ready_clr = 1'b1;
        @(negedge clk);
        ready_clr = 1'b0;
    endtask

    task automatic test_reset;
        tests++; if (data !== 8'h00)    begin fails++; $display("FAIL reset_data: got %h expected %h", data, 8'h00); end
        tests++; if (ready !== 1'b0)    begin fails++; $display("FAIL reset_ready: got %b expected %b", ready, 1'b0); end
        tests++; if (frame_err !== 1'b0) begin fails++; $display("FAIL reset_frame_err: got %b expected %b", frame_err, 1'b0); end
        tests++; if (overrun !== 1'b0)  begin fails++; $display("FAIL reset_overrun: got %b expected %b", overrun, 1'b0); end
        tests++; if (busy !== 1'b0)     begin fails++; $display("FAIL reset_busy: got %b expected %b", busy, 1'b0); end
        reset = 1'b0;
        drive_bit(1'b1);
        tests++; if (busy !== 1'b0)     begin fails++; $display("FAIL idle_busy: got %b expected %b", busy, 1'b0); end
    endtask

    task automatic test_basic;
        logic [7:0] v;
        v = 8'h55;
        drive_bit(1'b0);
        tests++; if (busy !== 1'b1) begin fails++; $display("FAIL basic_busy_mid: got %b expected %b", busy, 1'b1); end
        for (int i = 0; i < 8; i++) drive_bit(v[i]);
        drive_bit(1'b1);
        tests++; if (busy !== 1'b0)      begin fails++; $display("FAIL basic_busy_end: got %b expected %b", busy, 1'b0); end
        tests++; if (data !== 8'h55)     begin fails++; $display("FAIL basic_data: got %h expected %h", data, 8'h55); end
        tests++; if (ready !== 1'b1)     begin fails++; $display("FAIL basic_ready: got %b expected %b", ready, 1'b1); end
        tests++; if (frame_err !== 1'b0) begin fails++; $display("FAIL basic_frame_err: got %b expected %b", frame_err, 1'b0); end
        tests++; if (overrun !== 1'b0)   begin fails++; $display("FAIL basic_overrun: got %b expected %b", overrun, 1'b0); end
    endtask

    task automatic test_glitch;
        pulse_clr;
        tests++; if (ready !== 1'b0) begin fails++; $display("FAIL clr_ready: got %b expected %b", ready, 1'b0); end
        rx = 1'b0;
        repeat (12) @(negedge clk);
        tests++; if (busy !== 1'b1) begin fails++; $display("FAIL glitch_busy_start: got %b expected %b", busy, 1'b1); end
        rx = 1'b1;
        repeat (BIT_CLKS) @(negedge clk);
        tests++; if (busy !== 1'b0)  begin fails++; $display("FAIL glitch_busy_end: got %b expected %b", busy, 1'b0); end
        tests++; if (ready !== 1'b0) begin fails++; $display("FAIL glitch_ready: got %b expected %b", ready, 1'b0); end
        tests++; if (data !== 8'h55) begin fails++; $display("FAIL glitch_data: got %h expected %h", data, 8'h55); end
    endtask

    task automatic test_break;
        send_frame(8'hA3, 1'b0);
        rx = 1'b0;
        repeat (160) @(negedge clk);
        tests++; if (frame_err !== 1'b1) begin fails++; $display("FAIL break_frame_err: got %b expected %b", frame_err, 1'b1); end
        tests++; if (ready !== 1'b0)     begin fails++; $display("FAIL break_ready: got %b expected %b", ready, 1'b0); end
        tests++; if (data !== 8'h55)     begin fails++; $display("FAIL break_data: got %h expected %h", data, 8'h55); end
        tests++; if (busy !== 1'b1)      begin fails++; $display("FAIL break_busy: got %b expected %b", busy, 1'b1); end
        drive_bit(1'b1);
        drive_bit(1'b1);
        tests++; if (busy !== 1'b0)      begin fails++; $display("FAIL break_release_busy: got %b expected %b", busy, 1'b0); end
        tests++; if (frame_err !== 1'b1) begin fails++; $display("FAIL break_err_sticky: got %b expected %b", frame_err, 1'b1); end
        send_frame(8'h3C, 1'b1);
        tests++; if (data !== 8'h3C)     begin fails++; $display("FAIL recover_data: got %h expected %h", data, 8'h3C); end
        tests++; if (ready !== 1'b1)     begin fails++; $display("FAIL recover_ready: got %b expected %b", ready, 1'b1); end
        tests++; if (frame_err !== 1'b0) begin fails++; $display("FAIL recover_frame_err: got %b expected %b", frame_err, 1'b0); end
    endtask

    task automatic test_back_to_back;
        pulse_clr;
        drive_bit(1'b1);
        send_frame(8'h01, 1'b1);
        tests++; if (data !== 8'h01)   begin fails++; $display("FAIL b2b_first_data: got %h expected %h", data, 8'h01); end
        tests++; if (overrun !== 1'b0) begin fails++; $display("FAIL b2b_first_overrun: got %b expected %b", overrun, 1'b0); end
        send_frame(8'hFF, 1'b1);
        tests++; if (data !== 8'hFF)   begin fails++; $display("FAIL b2b_data: got %h expected %h", data, 8'hFF); end
        tests++; if (ready !== 1'b1)   begin fails++; $display("FAIL b2b_ready: got %b expected %b", ready, 1'b1); end
        tests++; if (overrun !== 1'b1) begin fails++; $display("FAIL b2b_overrun: got %b expected %b", overrun, 1'b1); end
        pulse_clr;
        tests++; if (ready !== 1'b0)   begin fails++; $display("FAIL b2b_clr_ready: got %b expected %b", ready, 1'b0); end
        tests++; if (overrun !== 1'b0) begin fails++; $display("FAIL b2b_clr_overrun: got %b expected %b", overrun, 1'b0); end
        tests++; if (data !== 8'hFF)   begin fails++; $display("FAIL b2b_clr_data: got %h expected %h", data, 8'hFF); end
    endtask

    task automatic test_clr_collision;
        logic [7:0] v;
        logic       seen;
        v    = 8'h7E;
        seen = 1'b0;
        drive_bit(1'b1);
        drive_bit(1'b0);
        for (int i = 0; i < 8; i++) drive_bit(v[i]);
        // Hold the acknowledge through the stop bit; the first cycle ready shows 1 proves the set beat the clear on the completion edge.
        rx        = 1'b1;
        ready_clr = 1'b1;
        for (int i = 0; i < BIT_CLKS; i++) begin
            @(negedge clk);
            if (!seen && ready === 1'b1) begin
                seen      = 1'b1;
                ready_clr = 1'b0;
            end
        end
        ready_clr = 1'b0;
        tests++; if (seen !== 1'b1)    begin fails++; $display("FAIL collide_seen: got %b expected %b", seen, 1'b1); end
        tests++; if (ready !== 1'b1)   begin fails++; $display("FAIL collide_ready: got %b expected %b", ready, 1'b1); end
        tests++; if (data !== 8'h7E)   begin fails++; $display("FAIL collide_data: got %h expected %h", data, 8'h7E); end
        tests++; if (overrun !== 1'b0) begin fails++; $display("FAIL collide_overrun: got %b expected %b", overrun, 1'b0); end
    endtask

    task automatic test_mid_reset;
        logic [7:0] v;
        v = 8'hC6;
        drive_bit(1'b1);
        drive_bit(1'b0);
        for (int i = 0; i < 4; i++) drive_bit(v[i]);
        tests++; if (busy !== 1'b1) begin fails++; $display("FAIL midrst_busy_before: got %b expected %b", busy, 1'b1); end
        reset = 1'b1;
        rx    = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        tests++; if (data !== 8'h00)     begin fails++; $display("FAIL midrst_data: got %h expected %h", data, 8'h00); end
        tests++; if (ready !== 1'b0)     begin fails++; $display("FAIL midrst_ready: got %b expected %b", ready, 1'b0); end
        tests++; if (frame_err !== 1'b0) begin fails++; $display("FAIL midrst_frame_err: got %b expected %b", frame_err, 1'b0); end
        tests++; if (overrun !== 1'b0)   begin fails++; $display("FAIL midrst_overrun: got %b expected %b", overrun, 1'b0); end
        tests++; if (busy !== 1'b0)      begin fails++; $display("FAIL midrst_busy: got %b expected %b", busy, 1'b0); end
        drive_bit(1'b1);
        drive_bit(1'b1);
        tests++; if (ready !== 1'b0) begin fails++; $display("FAIL midrst_no_byte: got %b expected %b", ready, 1'b0); end
        send_frame(8'h81, 1'b1);
        tests++; if (data !== 8'h81) begin fails++; $display("FAIL after_rst_data: got %h expected %h", data, 8'h81); end
        tests++; if (ready !== 1'b1) begin fails++; $display("FAIL after_rst_ready: got %b expected %b", ready, 1'b1); end
    endtask

    initial begin
        reset     = 1'b1;
        rx        = 1'b1;
        ready_clr = 1'b0;
        repeat (5) @(negedge clk);
        test_reset;
        test_basic;
        test_glitch;
        test_break;
        test_back_to_back;
        test_clr_collision;
        test_mid_reset;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
